// File: rtl/intr_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map,
// FSM encodings and CLAIM word layout.
package intr_ctrl_pkg;

    localparam logic [2:0] INTC_REG_MASK   = 3'd0;
    localparam logic [2:0] INTC_REG_MODE   = 3'd1;
    localparam logic [2:0] INTC_REG_PEND   = 3'd2;
    localparam logic [2:0] INTC_REG_CLAIM  = 3'd3;
    localparam logic [2:0] INTC_REG_EOI    = 3'd4;
    localparam logic [2:0] INTC_REG_STATUS = 3'd5;

    localparam int INTC_CLAIM_VALID_BIT = 31;

    typedef enum logic [1:0] {
        INTC_IDLE    = 2'b00,
        INTC_REQ     = 2'b01,
        INTC_SERVICE = 2'b10
    } intc_state_e;

    function automatic logic [31:0] intc_claim_word(
        input logic       valid,
        input logic [3:0] id
    );
        logic [31:0] w;
        w = '0;
        w[INTC_CLAIM_VALID_BIT] = valid;
        w[3:0] = id;
        return w;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
// Combinational; id is 0 when nothing is requested.
module intr_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [3:0]   id_o
);

    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                id_o    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Programmable interrupt controller: per-source mask/mode/pending,
// fixed-priority claim/EOI handshake and a registered CPU request.
import intr_ctrl_pkg::*;

module intr_ctrl #(
    parameter int NSRC        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [NSRC-1:0] i_src,
    output logic            o_intr,
    input  logic [2:0]      i_addr,
    input  logic            i_cmd,
    input  logic            i_rnw,
    input  logic [31:0]     i_wdata,
    output logic [31:0]     o_rdata,
    output logic            o_rdy,
    output logic [3:0]      o_active_id
);

    logic [NSRC-1:0] src_s;

    for (genvar s = 0; s < NSRC; s++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain_q;
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) chain_q <= '0;
            else       chain_q <= {chain_q[SYNC_STAGES-2:0], i_src[s]};
        end
        assign src_s[s] = chain_q[SYNC_STAGES-1];
    end

    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] prev_q;
    intc_state_e     state_q, state_d;
    logic [3:0]      active_q, active_d;
    logic            intr_q;
    logic            rdy_q;
    logic [31:0]     rdata_q, rdata_d;

    logic            wr, rd;
    logic [NSRC-1:0] cand;
    logic            win_v;
    logic [3:0]      win_id;
    logic            claim_hit, eoi_hit;
    logic [NSRC-1:0] rise, w1c, claim_clr;

    assign wr   = i_cmd & ~i_rnw;
    assign rd   = i_cmd & i_rnw;
    assign cand = pend_q & ~mask_q;

    intr_prio_enc #(.N(NSRC)) u_prio (
        .req_i   (cand),
        .valid_o (win_v),
        .id_o    (win_id)
    );

    assign claim_hit = rd && (i_addr == INTC_REG_CLAIM)
                       && (state_q == INTC_REQ) && win_v;
    assign eoi_hit   = wr && (i_addr == INTC_REG_EOI)
                       && (state_q == INTC_SERVICE);

    assign rise      = src_s & ~prev_q;
    assign w1c       = (wr && i_addr == INTC_REG_PEND) ?
                       i_wdata[NSRC-1:0] : '0;
    assign claim_clr = claim_hit ? (NSRC'(1) << win_id) : '0;

    // Edge bits: a fresh rising edge beats any clear in the same cycle.
    assign pend_d = (mode_q & ((pend_q & ~w1c & ~claim_clr) | rise))
                  | (~mode_q & src_s);

    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        if (wr && i_addr == INTC_REG_MASK) mask_d = i_wdata[NSRC-1:0];
        if (wr && i_addr == INTC_REG_MODE) mode_d = i_wdata[NSRC-1:0];
    end

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            case (i_addr)
                INTC_REG_MASK:   rdata_d = 32'(mask_q);
                INTC_REG_MODE:   rdata_d = 32'(mode_q);
                INTC_REG_PEND:   rdata_d = 32'(pend_q);
                INTC_REG_CLAIM:  rdata_d = claim_hit ?
                                 intc_claim_word(1'b1, win_id) : '0;
                INTC_REG_STATUS: rdata_d = {26'd0, state_q, active_q};
                default:         rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        unique case (state_q)
            INTC_IDLE: begin
                if (|cand) state_d = INTC_REQ;
            end
            INTC_REQ: begin
                if (claim_hit) begin
                    state_d  = INTC_SERVICE;
                    active_d = win_id;
                end else if (!win_v) begin
                    state_d = INTC_IDLE;
                end
            end
            INTC_SERVICE: begin
                if (eoi_hit) begin
                    state_d  = INTC_IDLE;
                    active_d = '0;
                end
            end
            default: begin
                state_d  = INTC_IDLE;
                active_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mask_q   <= '1;
            mode_q   <= '0;
            pend_q   <= '0;
            prev_q   <= '0;
            state_q  <= INTC_IDLE;
            active_q <= '0;
            intr_q   <= 1'b0;
            rdy_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            prev_q   <= src_s;
            state_q  <= state_d;
            active_q <= active_d;
            intr_q   <= (state_d == INTC_REQ);
            rdy_q    <= i_cmd;
            rdata_q  <= rdata_d;
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^i_wdata;

    assign o_intr      = intr_q;
    assign o_rdy       = rdy_q;
    assign o_rdata     = rdata_q;
    assign o_active_id = active_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: reads queue expected data, a
// negedge monitor pops on every o_rdy.
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  i_src = '0;
    logic        o_intr;
    logic [2:0]  i_addr = '0;
    logic        i_cmd = 1'b0;
    logic        i_rnw = 1'b0;
    logic [31:0] i_wdata = '0;
    logic [31:0] o_rdata;
    logic        o_rdy;
    logic [3:0]  o_active_id;

    intr_ctrl #(.NSRC(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_src       (i_src),
        .o_intr      (o_intr),
        .i_addr      (i_addr),
        .i_cmd       (i_cmd),
        .i_rnw       (i_rnw),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_rdy       (o_rdy),
        .o_active_id (o_active_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (nrst && o_rdy) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_rdy: got rdy=1 want no access");
            end else begin
                e = sbq.pop_front();
                if (e.chk) check(e.name, o_rdata, e.data);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e,
                      input string nm);
        sbq.push_back('{1'b1, e, nm});
        i_cmd = 1'b1; i_rnw = 1'b1; i_addr = a; i_wdata = '0;
        cyc(1);
        i_cmd = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        sbq.push_back('{1'b0, 32'd0, "write"});
        i_cmd = 1'b1; i_rnw = 1'b0; i_addr = a; i_wdata = d;
        cyc(1);
        i_cmd = 1'b0;
    endtask

    task automatic wait_intr(input logic e, input int max,
                             input string nm);
        for (int i = 0; i < max && o_intr !== e; i++) cyc(1);
        check(nm, 32'(o_intr), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int hi;
        nrst = 1'b0;
        cyc(2);
        nrst = 1'b1;
        i_src[3] = 1'b1;
        rd(3'd0, 32'h0000_00FF, "mask_rst");
        rd(3'd1, 32'h0, "mode_rst");
        rd(3'd5, 32'h0, "status_rst");
        hi = 0;
        repeat (20) begin
            cyc(1);
            if (o_intr) hi++;
        end
        check("intr_masked", hi, 0);

        // level source
        i_src[3] = 1'b0;
        cyc(4);
        wr(3'd0, 32'h0000_00F7);
        cyc(3);
        check("intr_no_level", 32'(o_intr), 0);
        i_src[3] = 1'b1;
        wait_intr(1'b1, 4, "lvl_raise");
        rd(3'd3, 32'h8000_0003, "claim_lvl");
        check("intr_in_service", 32'(o_intr), 0);
        check("active_lvl", 32'(o_active_id), 3);
        wr(3'd4, 32'h0);
        wait_intr(1'b1, 2, "lvl_reraise");
        rd(3'd5, 32'h10, "status_req");
        wr(3'd4, 32'h0);
        rd(3'd5, 32'h10, "status_eoi_in_req");
        check("intr_eoi_in_req", 32'(o_intr), 1);
        i_src[3] = 1'b0;
        wait_intr(1'b0, 5, "lvl_drop");
        rd(3'd5, 32'h0, "status_idle");

        // edge sources and priority
        wr(3'd1, 32'h0000_00FF);
        wr(3'd0, 32'h0);
        i_src[5] = 1'b1;
        cyc(1);
        i_src[5] = 1'b0;
        i_src[2] = 1'b1;
        cyc(1);
        i_src[2] = 1'b0;
        wait_intr(1'b1, 6, "edge_raise");
        cyc(2);
        rd(3'd3, 32'h8000_0002, "claim_edge2");
        wr(3'd4, 32'h0);
        wait_intr(1'b1, 3, "edge_second");
        rd(3'd3, 32'h8000_0005, "claim_edge5");
        wr(3'd4, 32'h0);
        rd(3'd2, 32'h0, "pend_after_claims");
        hi = 0;
        repeat (10) begin
            cyc(1);
            if (o_intr) hi++;
        end
        check("intr_quiet_edge", hi, 0);

        // W1C racing a synchronized rising edge
        wr(3'd0, 32'h0000_00FF);
        i_src[4] = 1'b1;
        cyc(2);
        wr(3'd2, 32'h10);
        rd(3'd2, 32'h10, "w1c_race");
        wr(3'd2, 32'h10);
        rd(3'd2, 32'h0, "w1c_clear");
        i_src[4] = 1'b0;

        // protocol misuse
        rd(3'd3, 32'h0, "claim_idle");
        rd(3'd7, 32'h0, "reg7");
        rd(3'd6, 32'h0, "reg6");
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd0, 32'h0000_00FF, "mask_after_w7");

        // reset during service
        wr(3'd0, 32'h0);
        i_src[6] = 1'b1;
        cyc(1);
        i_src[6] = 1'b0;
        wait_intr(1'b1, 6, "src6_raise");
        rd(3'd3, 32'h8000_0006, "claim6");
        check("active6", 32'(o_active_id), 6);
        cyc(1);
        nrst = 1'b0;
        #1;
        check("intr_in_rst", 32'(o_intr), 0);
        check("active_in_rst", 32'(o_active_id), 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        rd(3'd5, 32'h0, "status_after_rst");
        rd(3'd0, 32'h0000_00FF, "mask_after_rst");
        rd(3'd2, 32'h0, "pend_after_rst");

        cyc(3);
        check("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
